// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//   Fetch sequencer in front of the two-stage IF pipeline. It owns the program
//   counter and issues word-aligned requests to instruction memory over a
//   req/gnt/rvalid protocol. Granted fetches are tracked in an in-order slot
//   queue, and the head slot is presented as {pc, pc+4, instruction} to IF2
//   with a valid/ready handshake. A redirect flushes every slot. The number of
//   responses still owed by memory is remembered so that stale instructions
//   are discarded.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   redirect_valid_i/pc_i redirect request and target (low two bits ignored)
//   imem_req_o/addr_o     memory request and word-aligned address
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i/rdata_i in-order response and instruction word
//   inst_valid_o/ready_i  head-slot handshake towards IF2
//   inst_o, inst_pc_o, inst_pc_plus4_o  head slot contents (zero when empty)
// ---------------------------------------------------------------------------

// Flags a memory response that matches no outstanding or discarded fetch.
module if_fetch_ctrl_chk (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rvalid,
  input  logic i_drop_zero,
  input  logic i_unfilled_zero
);
  property p_no_orphan_rsp;
    @(posedge clk) disable iff (!rst_n)
      !(i_rvalid && i_drop_zero && i_unfilled_zero);
  endproperty

  a_no_orphan_rsp: assert property (p_no_orphan_rsp)
    else $error("if_fetch_ctrl: imem response with no outstanding fetch");
endmodule

module if_fetch_ctrl #(
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = {DATA_WIDTH{1'b0}},
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] inst_pc_o,
  output logic [DATA_WIDTH-1:0] inst_pc_plus4_o
);
  // Queue depth is 2..4, so a 2-bit pointer and a 3-bit count always suffice.
  localparam int PTR_W = (MAX_OUTSTANDING > 2) ? 2 : 1;
  localparam int CNT_W = (MAX_OUTSTANDING > 3) ? 3 : 2;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(MAX_OUTSTANDING - 1);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_pc_q;
  logic [DATA_WIDTH-1:0] r_slot_pc   [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] r_slot_inst [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_slot_filled;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [PTR_W-1:0]      r_fill;
  logic [CNT_W-1:0]      r_alloc_cnt;
  logic [CNT_W-1:0]      r_unfilled_cnt;
  logic [CNT_W-1:0]      r_drop_cnt;

  logic                  w_head_filled;
  logic                  w_pop;
  logic                  w_req;
  logic                  w_grant;
  logic                  w_fill;
  logic [CNT_W-1:0]      w_drop_redir;
  logic                  w_unused;

  // Circular increment; the queue depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == LAST_IDX) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Handshake, request and drop-count decode for the current cycle.
  always_comb begin
    w_head_filled = r_slot_filled[r_head];
    w_pop         = w_head_filled && !redirect_valid_i && inst_ready_i;
    w_req         = (r_state == ST_FETCH) && ((r_alloc_cnt < MAX_CNT) || w_pop)
                    && !redirect_valid_i;
    w_grant       = w_req && imem_gnt_i;
    // Accepted responses fill the oldest unfilled slot; a response in a
    // redirect cycle belongs to a flushed fetch and is counted out instead.
    w_fill        = imem_rvalid_i && (r_drop_cnt == {CNT_W{1'b0}})
                    && (r_unfilled_cnt != {CNT_W{1'b0}}) && !redirect_valid_i;
    // drop + unfilled never exceeds the depth: unfilled is zero while draining.
    w_drop_redir  = r_drop_cnt + r_unfilled_cnt;
    if (imem_rvalid_i && (w_drop_redir != {CNT_W{1'b0}})) begin
      w_drop_redir = w_drop_redir - CNT_W'(1);
    end else begin
      w_drop_redir = w_drop_redir;
    end
  end

  assign w_unused        = ^redirect_pc_i[1:0];
  assign imem_req_o      = w_req;
  assign imem_addr_o     = r_pc_q;
  assign inst_valid_o    = w_head_filled && !redirect_valid_i;
  assign inst_o          = w_head_filled ? r_slot_inst[r_head] : {DATA_WIDTH{1'b0}};
  assign inst_pc_o       = w_head_filled ? r_slot_pc[r_head]   : {DATA_WIDTH{1'b0}};
  assign inst_pc_plus4_o = w_head_filled ? (r_slot_pc[r_head] + DATA_WIDTH'(4))
                                         : {DATA_WIDTH{1'b0}};

  // Sequencer state: PC, queue pointers/counts, discard counter and FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_BOOT;
      r_pc_q         <= RESET_PC;
      r_head         <= {PTR_W{1'b0}};
      r_tail         <= {PTR_W{1'b0}};
      r_fill         <= {PTR_W{1'b0}};
      r_alloc_cnt    <= {CNT_W{1'b0}};
      r_unfilled_cnt <= {CNT_W{1'b0}};
      r_drop_cnt     <= {CNT_W{1'b0}};
    end else if (redirect_valid_i) begin
      r_pc_q         <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      r_head         <= {PTR_W{1'b0}};
      r_tail         <= {PTR_W{1'b0}};
      r_fill         <= {PTR_W{1'b0}};
      r_alloc_cnt    <= {CNT_W{1'b0}};
      r_unfilled_cnt <= {CNT_W{1'b0}};
      r_drop_cnt     <= w_drop_redir;
      r_state        <= (w_drop_redir != {CNT_W{1'b0}}) ? ST_DRAIN : ST_FETCH;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (w_grant) begin
            r_pc_q <= r_pc_q + DATA_WIDTH'(4);
            r_tail <= ptr_inc(r_tail);
          end
          if (w_pop) begin
            r_head <= ptr_inc(r_head);
          end
          if (w_fill) begin
            r_fill <= ptr_inc(r_fill);
          end
          r_alloc_cnt    <= r_alloc_cnt + CNT_W'(w_grant) - CNT_W'(w_pop);
          r_unfilled_cnt <= r_unfilled_cnt + CNT_W'(w_grant) - CNT_W'(w_fill);
        end
        ST_DRAIN: begin
          if (imem_rvalid_i && (r_drop_cnt != {CNT_W{1'b0}})) begin
            r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            if (r_drop_cnt == CNT_W'(1)) begin
              r_state <= ST_FETCH;
            end
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  // Slot storage: allocate on grant, fill on response, free on pop or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_filled <= {MAX_OUTSTANDING{1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_slot_pc[i]   <= {DATA_WIDTH{1'b0}};
        r_slot_inst[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (redirect_valid_i) begin
      r_slot_filled <= {MAX_OUTSTANDING{1'b0}};
    end else begin
      if (w_pop) begin
        r_slot_filled[r_head] <= 1'b0;
      end
      if (w_grant) begin
        r_slot_pc[r_tail]     <= r_pc_q;
        r_slot_filled[r_tail] <= 1'b0;
      end
      if (w_fill) begin
        r_slot_inst[r_fill]   <= imem_rdata_i;
        r_slot_filled[r_fill] <= 1'b1;
      end
    end
  end

  if_fetch_ctrl_chk u_chk (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_rvalid        (imem_rvalid_i),
    .i_drop_zero     (r_drop_cnt == {CNT_W{1'b0}}),
    .i_unfilled_zero (r_unfilled_cnt == {CNT_W{1'b0}})
  );
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
//   Randomized bench for if_fetch_ctrl. The stimulus process drives redirect,
//   grant, ready and an in-order memory with random latency. It predicts
//   imem_req_o/imem_addr_o and pushes every expected fetch into a scoreboard
//   queue. A separate monitor compares the IF2 handshake and data against the
//   head of that queue. A second instance, reset at 0xFFFF_FFF8, streams
//   continuously to exercise PC and PC+4 wrap-around.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;
  localparam int          MAXO    = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o, inst_pc_o, inst_pc_plus4_o;

  logic        w_req, w_rv, w_valid;
  logic [31:0] w_addr, w_rdata, w_inst, w_pc, w_pc4;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_pc_plus4_o(inst_pc_plus4_o)
  );

  if_fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(WRAP_PC), .MAX_OUTSTANDING(MAXO)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0000_0000),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
    .imem_rvalid_i(w_rv), .imem_rdata_i(w_rdata),
    .inst_valid_o(w_valid), .inst_ready_i(1'b1), .inst_o(w_inst),
    .inst_pc_o(w_pc), .inst_pc_plus4_o(w_pc4)
  );

  typedef struct { logic [31:0] pc; bit filled; } exp_t;
  typedef struct { logic [31:0] addr; int due; bit live; } mem_t;

  exp_t        exp_q[$];   // fetches granted and not yet delivered or flushed
  mem_t        mem_q[$];   // requests memory still owes a response for
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          booted = 1'b0;
  logic [31:0] model_pc = 32'h0000_0000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_q[i]) if (!mem_q[i].live) n++;
    return n;
  endfunction

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Wrap instance memory: fixed 1-cycle latency, every request granted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_rv    <= 1'b0;
      w_rdata <= 32'h0000_0000;
    end else begin
      w_rv    <= w_req;
      w_rdata <= mem_word(w_addr);
    end
  end

  // Wrap instance monitor: k-th delivered instruction is at WRAP_PC + 4k.
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        k = 0;
      end else if (w_valid) begin
        logic [31:0] e;
        e = WRAP_PC + 32'(k) * 32'd4;
        check("wrap_pc", w_pc, e);
        check("wrap_pc4", w_pc4, e + 32'd4);
        check("wrap_inst", w_inst, mem_word(e));
        k++;
      end
    end
  end

  // Main monitor: IF2 handshake against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        bit ev;
        ev = (exp_q.size() > 0) && exp_q[0].filled && !redirect_valid_i;
        check("inst_valid", {31'b0, inst_valid_o}, {31'b0, ev});
        if (ev) begin
          check("inst_pc", inst_pc_o, exp_q[0].pc);
          check("inst_pc_plus4", inst_pc_plus4_o, exp_q[0].pc + 32'd4);
          check("inst", inst_o, mem_word(exp_q[0].pc));
          if (inst_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus plus request prediction and model update.
  task automatic do_cycle(input bit rd, input logic [31:0] tgt,
                          input int gp, input int rp, input int yp);
    bit   rv, pop_now, exp_req;
    mem_t m;
    @(negedge clk);
    redirect_valid_i = rd;
    redirect_pc_i    = tgt;
    imem_gnt_i       = pct(gp);
    inst_ready_i     = pct(yp);
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && pct(rp);
    imem_rvalid_i    = rv;
    imem_rdata_i     = rv ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    pop_now = (exp_q.size() > 0) && exp_q[0].filled && inst_ready_i && !rd;
    exp_req = booted && (stale_cnt() == 0) && !rd && ((exp_q.size() < MAXO) || pop_now);
    check("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr_o, model_pc);
    #2;
    if (rv) begin
      m = mem_q.pop_front();
      if (m.live && !rd) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!exp_q[i].filled) begin
            exp_q[i].filled = 1'b1;
            break;
          end
        end
      end
    end
    if (rd) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].live = 1'b0;
      model_pc = {tgt[31:2], 2'b00};
    end else if (exp_req && imem_gnt_i) begin
      exp_q.push_back('{pc: model_pc, filled: 1'b0});
      mem_q.push_back('{addr: model_pc, due: cyc + 1, live: 1'b1});
      model_pc = model_pc + 32'd4;
    end
    booted = 1'b1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n            = 1'b0;
    redirect_valid_i = 1'b0;
    imem_gnt_i       = 1'b0;
    imem_rvalid_i    = 1'b0;
    inst_ready_i     = 1'b0;
    #1;
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", inst_pc_o, 32'd0);
    check("rst_pc4", inst_pc_plus4_o, 32'd0);
    check("rst_w_valid", {31'b0, w_valid}, 32'd0);
    check("rst_w_pc4", w_pc4, 32'd0);
    exp_q.delete();
    mem_q.delete();
    model_pc = 32'h0000_0000;
    booted   = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_random(input int blocks);
    for (int b = 0; b < blocks; b++) begin
      int gp, rp, yp;
      gp = int'($urandom_range(100, 30));
      rp = int'($urandom_range(100, 20));
      yp = int'($urandom_range(100, 20));
      for (int c = 0; c < 200; c++) begin
        bit          rd;
        logic [31:0] t;
        rd = pct(8);
        t  = pct(20) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
        do_cycle(rd, t, gp, rp, yp);
      end
    end
  endtask

  initial begin
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0000_0000;
    imem_gnt_i       = 1'b0;
    imem_rvalid_i    = 1'b0;
    imem_rdata_i     = 32'h0000_0000;
    inst_ready_i     = 1'b0;
    do_reset();
    // Streaming fetch from reset, then a 5-cycle stall and release.
    repeat (20) do_cycle(1'b0, 32'h0, 100, 100, 100);
    repeat (5)  do_cycle(1'b0, 32'h0, 100, 100, 0);
    repeat (10) do_cycle(1'b0, 32'h0, 100, 100, 100);
    // Redirect to 0x100 with fetches outstanding, then drain.
    repeat (3)  do_cycle(1'b0, 32'h0, 100, 0, 100);
    do_cycle(1'b1, 32'h0000_0100, 0, 0, 100);
    repeat (6)  do_cycle(1'b0, 32'h0, 100, 100, 100);
    // Back-to-back redirects while draining.
    repeat (2)  do_cycle(1'b0, 32'h0, 100, 0, 100);
    do_cycle(1'b1, 32'h0000_0040, 0, 0, 100);
    do_cycle(1'b1, 32'h0000_0080, 0, 100, 100);
    repeat (6)  do_cycle(1'b0, 32'h0, 100, 100, 100);
    // Redirect to an unaligned target coincident with a response.
    repeat (6)  do_cycle(1'b0, 32'h0, 0, 100, 100);
    do_cycle(1'b0, 32'h0, 100, 0, 100);
    do_cycle(1'b1, 32'h0000_0203, 0, 100, 100);
    repeat (4)  do_cycle(1'b0, 32'h0, 100, 100, 100);
    // Randomized traffic, a mid-run reset, more traffic.
    run_random(15);
    do_reset();
    run_random(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
